// File: rtl/pong_pkg.sv
// Shared types and default constants for the pong match sequencer.
package pong_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SERVE_WAIT = 3'd1,
      PLAY       = 3'd2,
      PAUSE      = 3'd3,
      GAME_OVER  = 3'd4
   } match_state_t;

   localparam int SCORE_W_DEF     = 4;
   localparam int WIN_SCORE_DEF   = 7;
   localparam int SERVE_DELAY_DEF = 30;

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the match sequencer (slave) and its environment (master).
// tick/miss are single-cycle strobes; keys are raw levels; state is a debug view.
interface pong_match_ctrl_if import pong_pkg::*; #(
   parameter int SCORE_W = SCORE_W_DEF
) ();
   logic               tick_i;
   logic               start_key_i;
   logic               pause_key_i;
   logic               miss_left_i;
   logic               miss_right_i;
   logic               run_o;
   logic               serve_o;
   logic               serve_dir_o;
   logic [SCORE_W-1:0] player_score_o;
   logic [SCORE_W-1:0] pc_score_o;
   logic               game_over_o;
   logic               winner_o;
   match_state_t       state;

   modport master (
      output tick_i, start_key_i, pause_key_i, miss_left_i, miss_right_i,
      input  run_o, serve_o, serve_dir_o, player_score_o, pc_score_o,
             game_over_o, winner_o, state
   );

   modport slave (
      input  tick_i, start_key_i, pause_key_i, miss_left_i, miss_right_i,
      output run_o, serve_o, serve_dir_o, player_score_o, pc_score_o,
             game_over_o, winner_o, state
   );
endinterface

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer for a raw button followed by a one-cycle rising-edge pulse.
module key_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_i,
   output logic pulse_o
);
   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign pulse_o = sync2_q & ~prev_q;
endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve timing, run enable, scoring and winner detection.
module pong_match_ctrl import pong_pkg::*; #(
   parameter int WIN_SCORE   = WIN_SCORE_DEF,
   parameter int SERVE_DELAY = SERVE_DELAY_DEF,
   parameter int SCORE_W     = SCORE_W_DEF
) (
   input logic              clk_i,
   input logic              rst_i,
   pong_match_ctrl_if.slave bus
);
   // A zero delay behaves as a one-tick delay, so the counter is never narrower than 1 bit.
   localparam int                 CNT_W    = (SERVE_DELAY < 1) ? 1 : $clog2(SERVE_DELAY + 1);
   localparam logic [CNT_W-1:0]   CNT_LOAD = (SERVE_DELAY < 1) ? CNT_W'(1) : CNT_W'(SERVE_DELAY);
   localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

   match_state_t       state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SCORE_W-1:0] player_q, player_d, pc_q, pc_d;
   logic [SCORE_W-1:0] player_inc, pc_inc;
   logic               dir_q, dir_d;
   logic               winner_q, winner_d;
   logic               serve_q, serve_d;
   logic               start_ev, pause_ev;

   key_sync_edge u_start (.clk_i(clk_i), .rst_i(rst_i), .key_i(bus.start_key_i), .pulse_o(start_ev));
   key_sync_edge u_pause (.clk_i(clk_i), .rst_i(rst_i), .key_i(bus.pause_key_i), .pulse_o(pause_ev));

   assign player_inc = player_q + SCORE_W'(1);
   assign pc_inc     = pc_q + SCORE_W'(1);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      player_d = player_q;
      pc_d     = pc_q;
      dir_d    = dir_q;
      winner_d = winner_q;
      serve_d  = 1'b0;
      case (state_q)
         IDLE, GAME_OVER: begin
            if (start_ev) begin
               player_d = '0;
               pc_d     = '0;
               dir_d    = 1'b1;
               winner_d = 1'b0;
               cnt_d    = CNT_LOAD;
               state_d  = SERVE_WAIT;
            end
         end
         SERVE_WAIT: begin
            if (bus.tick_i) begin
               if (cnt_q <= CNT_W'(1)) begin
                  cnt_d   = '0;
                  serve_d = 1'b1;
                  state_d = PLAY;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         PLAY: begin
            // Misses outrank a simultaneous pause; a double miss is a replay.
            if (bus.miss_left_i && bus.miss_right_i) begin
               cnt_d   = CNT_LOAD;
               state_d = SERVE_WAIT;
            end else if (bus.miss_left_i) begin
               player_d = player_inc;
               dir_d    = 1'b0;
               if (player_inc == WIN) begin
                  winner_d = 1'b1;
                  state_d  = GAME_OVER;
               end else begin
                  cnt_d   = CNT_LOAD;
                  state_d = SERVE_WAIT;
               end
            end else if (bus.miss_right_i) begin
               pc_d  = pc_inc;
               dir_d = 1'b1;
               if (pc_inc == WIN) begin
                  winner_d = 1'b0;
                  state_d  = GAME_OVER;
               end else begin
                  cnt_d   = CNT_LOAD;
                  state_d = SERVE_WAIT;
               end
            end else if (pause_ev) begin
               state_d = PAUSE;
            end
         end
         PAUSE: begin
            if (pause_ev) state_d = PLAY;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         player_q <= '0;
         pc_q     <= '0;
         dir_q    <= 1'b1;
         winner_q <= 1'b0;
         serve_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         player_q <= player_d;
         pc_q     <= pc_d;
         dir_q    <= dir_d;
         winner_q <= winner_d;
         serve_q  <= serve_d;
      end
   end

   assign bus.run_o          = (state_q == PLAY);
   assign bus.game_over_o    = (state_q == GAME_OVER);
   assign bus.serve_o        = serve_q;
   assign bus.serve_dir_o    = dir_q;
   assign bus.player_score_o = player_q;
   assign bus.pc_score_o     = pc_q;
   assign bus.winner_o       = winner_q;
   assign bus.state          = state_q;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with hand-computed expectations.
module tb_pong_match_ctrl;
   import pong_pkg::*;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   pong_match_ctrl_if #(.SCORE_W(4)) bus ();

   pong_match_ctrl #(.WIN_SCORE(7), .SERVE_DELAY(30), .SCORE_W(4)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick_i = 1'b1;
         cyc();
         bus.tick_i = 1'b0;
         cyc();
      end
   endtask

   // 30 ticks; on the last one the serve pulse and PLAY are checked.
   task automatic serve(input int dir);
      ticks(29);
      chk("pre_serve_state", int'(bus.state), int'(SERVE_WAIT));
      bus.tick_i = 1'b1;
      cyc();
      bus.tick_i = 1'b0;
      chk("serve_pulse", int'(bus.serve_o), 1);
      chk("serve_dir", int'(bus.serve_dir_o), dir);
      chk("serve_run", int'(bus.run_o), 1);
      cyc();
      chk("serve_once", int'(bus.serve_o), 0);
   endtask

   task automatic press_start(input int hold);
      bus.start_key_i = 1'b1;
      repeat (hold) cyc();
      bus.start_key_i = 1'b0;
      repeat (3 - ((hold > 2) ? 2 : hold - 1) - 1) cyc();
   endtask

   task automatic press_pause();
      bus.pause_key_i = 1'b1;
      cyc();
      bus.pause_key_i = 1'b0;
      cyc();
      cyc();
   endtask

   task automatic miss(input logic l, input logic r);
      bus.miss_left_i  = l;
      bus.miss_right_i = r;
      cyc();
      bus.miss_left_i  = 1'b0;
      bus.miss_right_i = 1'b0;
   endtask

   initial begin
      vectors         = 0;
      miscompares     = 0;
      rst             = 1'b1;
      bus.tick_i      = 1'b0;
      bus.start_key_i = 1'b0;
      bus.pause_key_i = 1'b0;
      bus.miss_left_i = 1'b0;
      bus.miss_right_i = 1'b0;
      cyc();
      cyc();
      chk("rst_state", int'(bus.state), int'(IDLE));
      chk("rst_run", int'(bus.run_o), 0);
      chk("rst_serve", int'(bus.serve_o), 0);
      chk("rst_dir", int'(bus.serve_dir_o), 1);
      chk("rst_player", int'(bus.player_score_o), 0);
      chk("rst_pc", int'(bus.pc_score_o), 0);
      chk("rst_go", int'(bus.game_over_o), 0);
      chk("rst_win", int'(bus.winner_o), 0);
      rst = 1'b0;
      cyc();
      chk("idle_hold", int'(bus.state), int'(IDLE));

      // Start held for 3 cycles: event lands on the third sampling edge.
      press_start(3);
      chk("start_state", int'(bus.state), int'(SERVE_WAIT));
      chk("start_player", int'(bus.player_score_o), 0);
      chk("start_pc", int'(bus.pc_score_o), 0);
      chk("start_run", int'(bus.run_o), 0);
      cyc();
      cyc();
      chk("start_still_wait", int'(bus.state), int'(SERVE_WAIT));
      serve(1);
      chk("play_state", int'(bus.state), int'(PLAY));

      miss(1'b1, 1'b0);
      chk("ml_player", int'(bus.player_score_o), 1);
      chk("ml_dir", int'(bus.serve_dir_o), 0);
      chk("ml_run", int'(bus.run_o), 0);
      chk("ml_state", int'(bus.state), int'(SERVE_WAIT));
      serve(0);

      miss(1'b0, 1'b1);
      chk("mr_pc", int'(bus.pc_score_o), 1);
      chk("mr_dir", int'(bus.serve_dir_o), 1);
      serve(1);

      miss(1'b1, 1'b1);
      chk("both_player", int'(bus.player_score_o), 1);
      chk("both_pc", int'(bus.pc_score_o), 1);
      chk("both_dir", int'(bus.serve_dir_o), 1);
      chk("both_state", int'(bus.state), int'(SERVE_WAIT));
      serve(1);

      press_pause();
      chk("pause_state", int'(bus.state), int'(PAUSE));
      chk("pause_run", int'(bus.run_o), 0);
      miss(1'b1, 1'b0);
      chk("pause_miss_ign", int'(bus.player_score_o), 1);
      press_start(1);
      chk("pause_start_ign", int'(bus.state), int'(PAUSE));
      press_pause();
      chk("resume_state", int'(bus.state), int'(PLAY));
      chk("resume_run", int'(bus.run_o), 1);

      // Pause event and a miss on the same edge: the miss wins.
      bus.pause_key_i = 1'b1;
      cyc();
      bus.pause_key_i = 1'b0;
      cyc();
      miss(1'b1, 1'b0);
      chk("pm_player", int'(bus.player_score_o), 2);
      chk("pm_state", int'(bus.state), int'(SERVE_WAIT));
      cyc();
      cyc();
      chk("pm_no_late_pause", int'(bus.state), int'(SERVE_WAIT));

      for (int p = 3; p <= 6; p++) begin
         serve(0);
         miss(1'b1, 1'b0);
         chk("run_up_player", int'(bus.player_score_o), p);
      end
      serve(0);
      miss(1'b1, 1'b0);
      chk("win_player", int'(bus.player_score_o), 7);
      chk("win_go", int'(bus.game_over_o), 1);
      chk("win_winner", int'(bus.winner_o), 1);
      chk("win_run", int'(bus.run_o), 0);
      miss(1'b0, 1'b1);
      miss(1'b1, 1'b0);
      chk("go_pc_hold", int'(bus.pc_score_o), 1);
      chk("go_player_hold", int'(bus.player_score_o), 7);
      chk("go_winner_hold", int'(bus.winner_o), 1);

      press_start(1);
      chk("new_state", int'(bus.state), int'(SERVE_WAIT));
      chk("new_player", int'(bus.player_score_o), 0);
      chk("new_pc", int'(bus.pc_score_o), 0);
      chk("new_go", int'(bus.game_over_o), 0);
      chk("new_dir", int'(bus.serve_dir_o), 1);

      serve(1); miss(1'b1, 1'b0);
      serve(0); miss(1'b1, 1'b0);
      serve(0); miss(1'b1, 1'b0);
      serve(0); miss(1'b0, 1'b1);
      serve(1); miss(1'b0, 1'b1);
      chk("mid_player", int'(bus.player_score_o), 3);
      chk("mid_pc", int'(bus.pc_score_o), 2);
      serve(1);

      // Asynchronous reset asserted between edges while in PLAY.
      #2 rst = 1'b1;
      #1;
      chk("arst_state", int'(bus.state), int'(IDLE));
      chk("arst_run", int'(bus.run_o), 0);
      chk("arst_player", int'(bus.player_score_o), 0);
      chk("arst_pc", int'(bus.pc_score_o), 0);
      chk("arst_dir", int'(bus.serve_dir_o), 1);
      chk("arst_go", int'(bus.game_over_o), 0);
      cyc();
      rst = 1'b0;
      cyc();
      chk("post_rst_state", int'(bus.state), int'(IDLE));
      chk("post_rst_serve", int'(bus.serve_o), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout vectors=%0d", vectors);
      $fatal(1, "timeout");
   end
endmodule
